// File: rtl/tx_reset_pkg.sv
// Purpose  : shared state encoding, default timing constants and helpers for the user reset generator.
// Latency  : n/a (declarations only).
// Backpres.: n/a (declarations only).
package tx_reset_pkg;

    // Reset-request sequencer states
    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        DEBOUNCE     = 3'd1,
        PULSE        = 3'd2,
        WAIT_RELEASE = 3'd3,
        HOLDOFF      = 3'd4
    } state_t;

    // Default timing: 10 ms debounce at 100 MHz, 16-cycle pulse, 256-cycle hold-off
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_PULSE_CYCLES    = 16;
    localparam int DEF_HOLDOFF_CYCLES  = 256;
    localparam int DEF_SYNC_STAGES     = 2;

    // Largest of three values; sizes the shared counter
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Purpose  : generic multi-flop synchroniser for a single asynchronous input.
// Latency  : STAGES clk cycles from din to dout.
// Backpres.: none; free-running sampler.
//
// Ports:
//   clk  - destination clock
//   rst  - synchronous active-high reset, clears the whole chain
//   din  - asynchronous input
//   dout - synchronised output (last stage)
module sync_ff #(
    parameter int STAGES = 2    // minimum 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
        end
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/user_reset_gen.sv
// Purpose  : debounced push-button / software-request user reset pulse generator with hold-off.
// Latency  : sw_req -> user_rst next cycle; btn_in -> user_rst after SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles.
// Backpres.: requests arriving outside IDLE are dropped (no sw_ack); busy flags the non-accepting window.
//
// Ports:
//   clk      - system clock
//   rst      - synchronous active-high reset
//   btn_in   - raw asynchronous push button, active-high
//   sw_req   - single-cycle software reset request
//   sw_ack   - one-cycle acknowledge, coincides with the first user_rst cycle
//   user_rst - registered active-high reset request to the combiner
//   busy     - high whenever the sequencer is not in IDLE
module user_reset_gen
    import tx_reset_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
    parameter int HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES,
    parameter int CNT_W           = $clog2(max3(DEBOUNCE_CYCLES, PULSE_CYCLES, HOLDOFF_CYCLES) + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    input  logic sw_req,
    output logic sw_ack,
    output logic user_rst,
    output logic busy
);

    // Terminal counts. PULSE and HOLDOFF count from 0, so their last value is N-1;
    // a zero hold-off still spends one cycle in HOLDOFF.
    localparam logic [CNT_W-1:0] DEB_MAX    = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'((PULSE_CYCLES > 0) ? PULSE_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              from_btn;   // pulse source: 1 = button, 0 = software
    logic              btn_s;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_btn_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_in),
        .dout (btn_s)
    );

    // Saturating increment: the counter never wraps
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            user_rst <= 1'b0;
            sw_ack   <= 1'b0;
            busy     <= 1'b0;
            from_btn <= 1'b0;
        end else begin
            sw_ack <= 1'b0;
            case (state)
                IDLE: begin
                    // Software request wins over a simultaneous button press
                    if (sw_req) begin
                        state    <= PULSE;
                        cnt      <= '0;
                        user_rst <= 1'b1;
                        sw_ack   <= 1'b1;
                        busy     <= 1'b1;
                        from_btn <= 1'b0;
                    end else if (btn_s) begin
                        state <= DEBOUNCE;
                        cnt   <= CNT_W'(1);
                        busy  <= 1'b1;
                    end
                end

                DEBOUNCE: begin
                    if (!btn_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt >= DEB_MAX) begin
                        state    <= PULSE;
                        cnt      <= '0;
                        user_rst <= 1'b1;
                        from_btn <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                PULSE: begin
                    // user_rst was raised on entry; drop it after PULSE_CYCLES cycles
                    if (cnt >= PULSE_LAST) begin
                        user_rst <= 1'b0;
                        cnt      <= '0;
                        state    <= from_btn ? WAIT_RELEASE : HOLDOFF;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                WAIT_RELEASE: begin
                    // A held button yields a single pulse
                    if (!btn_s) begin
                        state <= HOLDOFF;
                        cnt   <= '0;
                    end
                end

                HOLDOFF: begin
                    if (cnt >= HOLD_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    user_rst <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_user_reset_gen.sv
// Purpose  : directed self-checking bench for user_reset_gen (DEBOUNCE=4, PULSE=3, HOLDOFF=5, SYNC=2).
// Latency  : inputs driven 1 time unit after each rising edge, outputs sampled at the same point.
// Backpres.: n/a.
module tb_user_reset_gen;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic sw_req;
    logic sw_ack;
    logic user_rst;
    logic busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    user_reset_gen #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .PULSE_CYCLES    (3),
        .HOLDOFF_CYCLES  (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .sw_req   (sw_req),
        .sw_ack   (sw_ack),
        .user_rst (user_rst),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [20:1] b_in;
        logic [20:1] b_busy;
        int first_rst;
        int rst_ones;

        // ---------------- reset with all requests active ----------------
        rst    = 1'b1;
        btn_in = 1'b1;
        sw_req = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("rst_user_rst", user_rst, 0);
            check("rst_sw_ack",   sw_ack,   0);
            check("rst_busy",     busy,     0);
        end
        rst    = 1'b0;
        btn_in = 1'b0;
        sw_req = 1'b0;
        tick();
        check("rst_rel_busy", busy, 0);
        check("rst_rel_user_rst", user_rst, 0);
        tick();
        tick();

        // ---------------- bounce: 3 high / 1 low, four times ----------------
        // bit k = value at edge k
        b_in   = 20'b00000_111_0_111_0_111_0_111;
        b_busy = 20'b000_111_0_111_0_111_0_111_00;
        for (int k = 1; k <= 20; k++) begin
            btn_in = b_in[k];
            tick();
            check("bounce_user_rst", user_rst, 0);
            check("bounce_busy",     busy,     b_busy[k]);
        end

        // ---------------- clean press held for 40 cycles ----------------
        first_rst = 0;
        rst_ones  = 0;
        for (int k = 1; k <= 40; k++) begin
            btn_in = 1'b1;
            tick();
            if (user_rst === 1'b1) begin
                rst_ones++;
                if (first_rst == 0) first_rst = k;
            end
            check("press_user_rst", user_rst, (k >= 7 && k <= 9));
            check("press_busy",     busy,     (k >= 3));
        end
        check("press_first_edge", first_rst, 7);
        check("press_pulse_len",  rst_ones,  3);
        for (int k = 1; k <= 10; k++) begin
            btn_in = 1'b0;
            tick();
            check("release_user_rst", user_rst, 0);
            check("release_busy",     busy,     (k <= 7));
        end

        // ---------------- software request ----------------
        for (int k = 1; k <= 12; k++) begin
            sw_req = (k == 1);
            tick();
            check("sw_user_rst", user_rst, (k <= 3));
            check("sw_ack",      sw_ack,   (k == 1));
            check("sw_busy",     busy,     (k <= 8));
        end

        // ---------------- simultaneous sw_req/btn_s, then sw_req in HOLDOFF ----------------
        for (int k = 1; k <= 16; k++) begin
            btn_in = (k <= 4);
            sw_req = (k == 3 || k == 8);
            tick();
            check("simul_user_rst", user_rst, (k >= 3 && k <= 5));
            check("simul_sw_ack",   sw_ack,   (k == 3));
            check("simul_busy",     busy,     (k >= 3 && k <= 10));
        end
        btn_in = 1'b0;
        sw_req = 1'b0;

        // ---------------- reset during the pulse, then a fresh request ----------------
        for (int k = 1; k <= 16; k++) begin
            sw_req = (k == 1 || k == 12);
            rst    = (k == 3);
            tick();
            check("midrst_user_rst", user_rst, (k <= 2) || (k >= 12 && k <= 14));
            check("midrst_sw_ack",   sw_ack,   (k == 1 || k == 12));
            check("midrst_busy",     busy,     (k <= 2) || (k >= 12));
        end
        sw_req = 1'b0;
        rst    = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
